// File: rtl/pool_ctrl_pkg.sv
// Shared types and defaults for the max-pool sequencer: state enum (2-bit encoding also used
// on the debug bus) and default window geometry.
package pool_ctrl_pkg;

  localparam int unsigned StateW    = 2;
  localparam int unsigned DefNumWin = 9;
  localparam int unsigned DefCntW   = 4;

  typedef enum logic [StateW-1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } pool_state_e;

endpackage

// File: rtl/pool_seq_wdog.sv
// Watchdog for the WAIT state: counts consecutive WAIT cycles and raises a sticky error.
// Only instantiated when POOL_SEQ_CTRL_TIMEOUT_EN is defined.
module pool_seq_wdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  input  logic pool_out_vld,
  output logic fire,
  output logic err_timeout
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  localparam logic [WdogW-1:0] LastCnt = WdogW'(TIMEOUT - 1);

  logic [WdogW-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Fires on the TIMEOUT-th consecutive WAIT cycle that still has no completion strobe.
  assign fire        = in_wait & ~pool_out_vld & (cnt_q == LastCnt);
  assign err_timeout = err_q;

  always_comb begin
    cnt_d = '0;
    err_d = err_q | fire;
    if (in_wait && !fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/pool_seq_ctrl.sv
// Sequencer for the 2x2 max-pool datapath: accept conv frame, strobe NUM_WIN windows, wait for
// completion, hold pooled frame for downstream. Optional watchdog: POOL_SEQ_CTRL_TIMEOUT_EN.
module pool_seq_ctrl
  import pool_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WIN = DefNumWin,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned FCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_vld,
  output logic              up_rdy,
  output logic              lat_en,
  output logic              pool_in_vld,
  output logic [CNT_W-1:0]  pool_win_idx,
  input  logic              pool_out_vld,
  output logic              dn_vld,
  input  logic              dn_rdy,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_timeout
);

  if (NUM_WIN < 1 || NUM_WIN > (32'd1 << CNT_W) || TIMEOUT < 1) begin : g_param_check
    $error("pool_seq_ctrl: NUM_WIN must fit in CNT_W bits and TIMEOUT must be nonzero");
  end

  localparam logic [CNT_W-1:0] LastWin = CNT_W'(NUM_WIN - 1);

  pool_state_e       state_q, state_d;
  logic [CNT_W-1:0]  win_idx_q, win_idx_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              wdog_fire;

`ifdef POOL_SEQ_CTRL_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state_q == StWait);

  pool_seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .in_wait      (in_wait),
    .pool_out_vld (pool_out_vld),
    .fire         (wdog_fire),
    .err_timeout  (err_timeout)
  );
`else
  assign wdog_fire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    win_idx_d   = win_idx_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (up_vld) begin
          state_d   = StRun;
          win_idx_d = '0;
        end
      end
      StRun: begin
        if (win_idx_q == LastWin) begin
          state_d   = StWait;
          win_idx_d = '0;
        end else begin
          win_idx_d = win_idx_q + 1'b1;
        end
      end
      StWait: begin
        // Completion wins over a same-cycle watchdog expiry.
        if (pool_out_vld) begin
          state_d = StHold;
        end else if (wdog_fire) begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (dn_rdy) begin
          state_d     = StIdle;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      win_idx_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      win_idx_q   <= win_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign up_rdy       = (state_q == StIdle) & ~rst;
  assign lat_en       = up_vld & up_rdy;
  assign pool_in_vld  = (state_q == StRun);
  assign dn_vld       = (state_q == StHold);
  assign busy         = (state_q != StIdle);
  assign pool_win_idx = win_idx_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Self-checking bench for pool_seq_ctrl: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pool_seq_ctrl;

  localparam int unsigned NumWin  = 9;
  localparam int unsigned CntW    = 4;
  localparam int unsigned Timeout = 64;
  localparam int unsigned FcntW   = 16;
`ifdef POOL_SEQ_CTRL_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, up_vld, up_rdy, lat_en, pool_in_vld, pool_out_vld;
  logic             dn_vld, dn_rdy, busy, err_timeout;
  logic [CntW-1:0]  pool_win_idx;
  logic [FcntW-1:0] frame_cnt;

  logic dp_en, dp_out, spur, chk_en, lw;
  int   n_vec = 0;
  int   n_err = 0;

  // Datapath stand-in: completion strobe one cycle after the last window, plus injected strobes.
  assign pool_out_vld = dp_out | spur;

  pool_seq_ctrl #(
    .NUM_WIN (NumWin),
    .CNT_W   (CntW),
    .TIMEOUT (Timeout),
    .FCNT_W  (FcntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .up_vld       (up_vld),
    .up_rdy       (up_rdy),
    .lat_en       (lat_en),
    .pool_in_vld  (pool_in_vld),
    .pool_win_idx (pool_win_idx),
    .pool_out_vld (pool_out_vld),
    .dn_vld       (dn_vld),
    .dn_rdy       (dn_rdy),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .err_timeout  (err_timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    dp_out = 1'b0;
    forever begin
      @(negedge clk);
      lw = dp_en && pool_in_vld && (pool_win_idx == CntW'(NumWin - 1));
      @(posedge clk);
      #1 dp_out = lw;
    end
  end

  // Reference model: a frame is described by its accept cycle and its completion cycle.
  int             cyc = 0;
  int             acc = -1;
  int             done = -1;
  int             off;
  logic [FcntW-1:0] m_fcnt = '0;
  bit             m_err = 1'b0;
  bit             idle, e_up_rdy, e_lat, e_pin, e_dn;
  int             e_idx;

  initial forever begin
    @(negedge clk);
    idle     = (acc < 0);
    off      = cyc - acc;
    e_up_rdy = idle && !rst;
    e_lat    = e_up_rdy && up_vld;
    e_pin    = !idle && off >= 1 && off <= NumWin;
    e_idx    = e_pin ? off - 1 : 0;
    e_dn     = !idle && done >= 0 && cyc > done;
    if (chk_en) begin
      chk("up_rdy", 32'(up_rdy), 32'(e_up_rdy));
      chk("lat_en", 32'(lat_en), 32'(e_lat));
      chk("pool_in_vld", 32'(pool_in_vld), 32'(e_pin));
      chk("pool_win_idx", 32'(pool_win_idx), e_idx);
      chk("dn_vld", 32'(dn_vld), 32'(e_dn));
      chk("busy", 32'(busy), 32'(!idle));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
    end
    if (rst) begin
      acc = -1; done = -1; m_fcnt = '0; m_err = 1'b0;
    end else if (idle) begin
      if (up_vld) begin acc = cyc; done = -1; end
    end else if (e_dn) begin
      if (dn_rdy) begin m_fcnt = m_fcnt + 1'b1; acc = -1; end
    end else if (done < 0 && off >= NumWin + 1) begin
      if (pool_out_vld) done = cyc;
      else if (TmoEn && off == NumWin + Timeout) begin m_err = 1'b1; acc = -1; end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Accept one frame from IDLE, then observe offsets 1..n after the accept cycle.
  task automatic run_frame(input int n, input int spur_at, output int pin_cnt,
                           output int pin_first, output int dn_cnt, output int dn_first);
    up_vld = 1'b1;
    @(negedge clk);
    chk("accept_lat_en", 32'(lat_en), 32'd1);
    @(posedge clk); #1;
    up_vld = 1'b0;
    pin_cnt = 0; pin_first = -1; dn_cnt = 0; dn_first = -1;
    for (int i = 1; i <= n; i++) begin
      spur = (i == spur_at);
      @(negedge clk);
      if (pool_in_vld) begin pin_cnt++; if (pin_first < 0) pin_first = i; end
      if (dn_vld) begin dn_cnt++; if (dn_first < 0) dn_first = i; end
      @(posedge clk); #1;
    end
    spur = 1'b0;
  endtask

  int pc, pf, dc, df, run, max_run, first_err, dn_seen;
  int acc_q[$];

  initial begin
    rst = 1'b1; up_vld = 1'b0; dn_rdy = 1'b0; dp_en = 1'b1; spur = 1'b0; chk_en = 1'b0;
    tick(2);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_up_rdy", 32'(up_rdy), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single frame, downstream always ready.
    dn_rdy = 1'b1;
    run_frame(14, 0, pc, pf, dc, df);
    chk("single_pin_cnt", pc, 9);
    chk("single_pin_first", pf, 1);
    chk("single_dn_cnt", dc, 1);
    chk("single_dn_first", df, 11);
    @(negedge clk);
    chk("single_frame_cnt", 32'(frame_cnt), 32'd1);
    @(posedge clk); #1;

    // Backpressure: dn_rdy low for 5 cycles of dn_vld.
    dn_rdy = 1'b0;
    run_frame(11, 0, pc, pf, dc, df);
    chk("bp_dn_first", df, 11);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_dn_hold", 32'(dn_vld), 32'd1);
      chk("bp_up_rdy", 32'(up_rdy), 32'd0);
      chk("bp_frame_cnt", 32'(frame_cnt), 32'd1);
      @(posedge clk); #1;
    end
    dn_rdy = 1'b1;
    @(negedge clk);
    chk("bp_hs_frame_cnt", 32'(frame_cnt), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("bp_after_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Back-to-back frames after a counter reset.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    up_vld = 1'b1;
    run = 0; max_run = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (lat_en) begin acc_q.push_back(i); run++; end
      else run = 0;
      if (run > max_run) max_run = run;
      @(posedge clk); #1;
    end
    up_vld = 1'b0;
    chk("b2b_accepts", acc_q.size(), 4);
    chk("b2b_pulse_len", max_run, 1);
    for (int k = 0; k < acc_q.size() && k < 4; k++) chk("b2b_accept_cycle", acc_q[k], 12 * k);
    @(negedge clk);
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'd4);
    @(posedge clk); #1;

    // Spurious completion strobe in IDLE and in RUN window 3.
    spur = 1'b1;
    @(negedge clk);
    chk("spur_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy_next", 32'(busy), 32'd0);
    @(posedge clk); #1;
    run_frame(14, 4, pc, pf, dc, df);
    chk("spur_pin_cnt", pc, 9);
    chk("spur_dn_first", df, 11);

    // Reset in RUN at window 5.
    up_vld = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    up_vld = 1'b0;
    tick(5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_idx_before", 32'(pool_win_idx), 32'd5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pin", 32'(pool_in_vld), 32'd0);
    chk("mid_rst_idx", 32'(pool_win_idx), 32'd0);
    chk("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_up_rdy", 32'(up_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(14, 0, pc, pf, dc, df);
    chk("post_rst_pin_first", pf, 1);
    chk("post_rst_pin_cnt", pc, 9);

    // Completion never returned by the datapath.
    dp_en = 1'b0;
    up_vld = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    up_vld = 1'b0;
    first_err = -1; dn_seen = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (err_timeout && first_err < 0) first_err = i;
      if (dn_vld) dn_seen++;
      @(posedge clk); #1;
    end
    chk("stall_dn_seen", dn_seen, 0);
`ifdef POOL_SEQ_CTRL_TIMEOUT_EN
    chk("tmo_err_cycle", first_err, 74);
    @(negedge clk);
    chk("tmo_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    dp_en = 1'b1;
    run_frame(14, 0, pc, pf, dc, df);
    chk("tmo_next_dn_cnt", dc, 1);
    @(negedge clk);
    chk("tmo_err_sticky", 32'(err_timeout), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    chk("tmo_err_cleared", 32'(err_timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
`else
    chk("stall_no_err", first_err, -1);
    @(negedge clk);
    chk("stall_still_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    dp_en = 1'b1;
    @(negedge clk);
    chk("stall_release_dn", 32'(dn_vld), 32'd1);
    @(posedge clk); #1;
`endif
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
